nios_system_multi_timer: RTL and testbench
==========================================

NIOS_SYSTEM_MULTI_TIMER -- requirements
Module: nios_system_multi_timer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 4, timer channel count, legal 1-8.
- CNT_W, 32, counter/period width, legal 8-32.
- PRESCALE_W, 8, prescaler width, legal 1-16.
- RESET_PERIOD, 49999, period/counter reset value, truncated to CNT_W.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- address, in, clog2(NUM_CH)+3, bits[2:0] register, upper bits channel.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write.
- writedata, in, 32, write data.
- readdata, out, 32, registered read data.
- irq, out, 1, OR of irq_vec.
- irq_vec, out, NUM_CH, per-channel interrupt.
REQ-003 One clock SHALL be used; reset SHALL be synchronous and active-high.

Function
REQ-004 A write SHALL occur when chipselect=1 and write_n=0; a write to channel index >= NUM_CH SHALL be ignored.
REQ-005 Per-channel register map, by address[2:0]:
- 0 STATUS: bit0 TO, bit1 RUN; any write clears TO.
- 1 CONTROL: bit0 ITO, bit1 CONT, bit4 CHAIN are stored; bit2 START and bit3 STOP are strobes that read 0.
- 2 PERIOD, CNT_W bits.
- 3 SNAP: write captures the counter; read returns the capture.
- 4 PRESCALE, PRESCALE_W bits.
- 5 IRQSUM: reads irq_vec, identical in every channel, read-only.
- 6-7 reserved, read 0.
REQ-006 readdata SHALL be registered every cycle from the addressed register: 1-cycle latency, no read strobe, unused bits zero.
REQ-007 Tick generation:
- Each channel has a prescale counter reloaded with PRESCALE on START, on PERIOD write, or on reaching 0.
- A tick occurs when the prescale counter is 0 and RUN=1.
- With CHAIN=1 and channel > 0, the tick is instead the previous channel's timeout event; CHAIN is ignored on channel 0.
REQ-008 On a tick, the counter SHALL decrement if nonzero. If zero, it SHALL reload PERIOD and raise a one-cycle timeout event, so period P yields a timeout every P+1 ticks.
REQ-009 A timeout event SHALL set TO. If CONT=0, it SHALL also clear RUN in the same cycle.
REQ-010 A START strobe SHALL set RUN. STOP SHALL clear RUN. When both are written together, START SHALL win.
REQ-011 A PERIOD write SHALL:
- clear RUN;
- set force_reload, so the counter loads the new PERIOD on the next cycle;
- let a later START begin from that value.
REQ-012 A START on the same cycle as force_reload SHALL leave RUN=1 and the counter loaded.
REQ-013 A STATUS write coincident with a timeout event SHALL leave TO=0 (clear wins).
REQ-014 A SNAP write SHALL capture the counter value before that cycle's update.
REQ-015 irq_vec[i] SHALL equal TO_i AND ITO_i, combinationally from registers. irq SHALL be the OR of irq_vec.
REQ-016 PRESCALE=0 SHALL tick every clock while running. PERIOD=0 SHALL time out on every tick.
REQ-017 Counter arithmetic SHALL be unsigned CNT_W with no wrap below 0; zero is the reload point.

Reset
REQ-018 On reset=1 at a clk edge, every channel SHALL be set as follows:
- counter = PERIOD = RESET_PERIOD;
- PRESCALE = 0;
- CONTROL = 0, RUN = 0, TO = 0;
- SNAP = 0, force_reload = 0.
REQ-019 Reset SHALL also drive readdata=0, irq=0 and irq_vec=0 from the next edge.
REQ-020 Reset mid-count SHALL abort the count with no timeout event and no interrupt.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Ch0 PERIOD=4, PRESCALE=0, CONTROL=0x7 → TO set 5 clocks after START; irq=1; counter continues 4,3,2,1,0,4…
- Ch1 PERIOD=2, PRESCALE=3, CONTROL=0x5 (one-shot) → single timeout 12 clocks after START; RUN=0 afterwards; a STATUS write clears irq_vec[1].
- Chain: ch0 PERIOD=1, CONT; ch1 PERIOD=2 with CHAIN|CONT|START → ch1 TO every 6 clocks.
- PERIOD write of 10 while running → RUN=0; counter=10 two cycles after the write; START resumes from 10.
- STATUS clear on the exact timeout cycle → TO stays 0. CONTROL=0xC → RUN=1.
- SNAP write on ch2 during countdown → a read at offset 3 returns the pre-decrement value one cycle later. Reset asserted mid-count → all outputs 0 and PERIOD=49999.

Source files
------------

// File: rtl/nios_system_multi_timer.sv
// Bank of NUM_CH prescaled down-counting timers behind a chipselect/write_n slave port,
// with optional chaining of a channel onto its predecessor's timeout and per-channel interrupts.
module nios_system_multi_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRESCALE_W   = 8,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         irq_vec
);

  localparam int unsigned ADDR_W = $clog2(NUM_CH) + 3;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_IRQSUM   = 3'd5;

  logic [2:0]      reg_sel;
  logic [CH_W-1:0] ch_sel;
  logic            ch_valid;
  logic            wr_en;
  logic [31:0]     rd_ch [NUM_CH];
  logic [31:0]     rd_mux;
  logic [31:0]     readdata_q;

  assign reg_sel = address[2:0];

  if (NUM_CH > 1) begin : g_ch_sel
    assign ch_sel = address[ADDR_W-1:3];
  end else begin : g_ch_sel_one
    assign ch_sel = 1'b0;
  end

  assign ch_valid = ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));
  assign wr_en    = chipselect && !write_n && ch_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      period_q;
    logic [CNT_W-1:0]      snap_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic                  ito_q, cont_q, chain_q;
    logic                  run_q, run_d;
    logic                  to_q, to_d;
    logic                  force_q;
    logic                  ch_hit;
    logic                  wr_status, wr_ctrl, wr_period, wr_snap, wr_presc;
    logic                  start, stop;
    logic                  chain_in, tick, evt;
    logic [31:0]           rd_val;

    assign ch_hit    = wr_en && (ch_sel == CH_W'(i));
    assign wr_status = ch_hit && (reg_sel == REG_STATUS);
    assign wr_ctrl   = ch_hit && (reg_sel == REG_CONTROL);
    assign wr_period = ch_hit && (reg_sel == REG_PERIOD);
    assign wr_snap   = ch_hit && (reg_sel == REG_SNAP);
    assign wr_presc  = ch_hit && (reg_sel == REG_PRESCALE);
    assign start     = wr_ctrl && writedata[2];
    assign stop      = wr_ctrl && writedata[3];

    // Chained channels count the predecessor's timeout events instead of prescaler ticks.
    if (i == 0) begin : g_head
      assign chain_in = 1'b0;
    end else begin : g_link
      assign chain_in = g_ch[i-1].evt;
    end

    always_comb begin
      if ((i != 0) && chain_q) begin
        tick = run_q && chain_in;
      end else begin
        tick = run_q && (presc_cnt_q == '0);
      end
    end

    assign evt = tick && !force_q && (cnt_q == '0);

    always_comb begin
      run_d = run_q;
      if (evt && !cont_q) run_d = 1'b0;
      if (stop)           run_d = 1'b0;
      if (start)          run_d = 1'b1;
      if (wr_period)      run_d = 1'b0;

      // Software clear beats a coincident timeout.
      to_d = to_q;
      if (evt)       to_d = 1'b1;
      if (wr_status) to_d = 1'b0;

      cnt_d = cnt_q;
      if (force_q) begin
        cnt_d = period_q;
      end else if (tick) begin
        cnt_d = (cnt_q == '0) ? period_q : cnt_q - CNT_W'(1);
      end

      presc_cnt_d = presc_cnt_q;
      if (start || wr_period || (presc_cnt_q == '0)) begin
        presc_cnt_d = presc_q;
      end else if (run_q) begin
        presc_cnt_d = presc_cnt_q - PRESCALE_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q       <= RST_PERIOD;
        period_q    <= RST_PERIOD;
        snap_q      <= '0;
        presc_q     <= '0;
        presc_cnt_q <= '0;
        ito_q       <= 1'b0;
        cont_q      <= 1'b0;
        chain_q     <= 1'b0;
        run_q       <= 1'b0;
        to_q        <= 1'b0;
        force_q     <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        presc_cnt_q <= presc_cnt_d;
        run_q       <= run_d;
        to_q        <= to_d;
        force_q     <= wr_period;
        if (wr_period) period_q <= writedata[CNT_W-1:0];
        if (wr_presc)  presc_q  <= writedata[PRESCALE_W-1:0];
        if (wr_snap)   snap_q   <= cnt_q;
        if (wr_ctrl) begin
          ito_q   <= writedata[0];
          cont_q  <= writedata[1];
          chain_q <= writedata[4];
        end
      end
    end

    assign irq_vec[i] = to_q && ito_q;

    always_comb begin
      case (reg_sel)
        REG_STATUS:   rd_val = {30'd0, run_q, to_q};
        REG_CONTROL:  rd_val = {27'd0, chain_q, 2'b00, cont_q, ito_q};
        REG_PERIOD:   rd_val = 32'(period_q);
        REG_SNAP:     rd_val = 32'(snap_q);
        REG_PRESCALE: rd_val = 32'(presc_q);
        REG_IRQSUM:   rd_val = 32'(irq_vec);
        default:      rd_val = '0;
      endcase
    end

    assign rd_ch[i] = rd_val;
  end

  // Out-of-range channels match no entry and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_sel == CH_W'(k)) rd_mux = rd_ch[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_nios_system_multi_timer.sv
// Directed bench for nios_system_multi_timer: bus writes/reads with hand-computed
// cycle timing for periodic, one-shot, chained, reload, clear-race and reset cases.
module tb_nios_system_multi_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  int n_cmp = 0;
  int n_err = 0;

  nios_system_multi_timer #(
    .NUM_CH      (4),
    .CNT_W       (32),
    .PRESCALE_W  (8),
    .RESET_PERIOD(49999)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_vec   (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input int ch, input int rg, input logic [31:0] d);
    address    = 5'(ch * 8 + rg);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_rd(input int ch, input int rg, output logic [31:0] d);
    address = 5'(ch * 8 + rg);
    step(1);
    d = readdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] snap_exp [4];
    snap_exp[0] = 32'd4;
    snap_exp[1] = 32'd2;
    snap_exp[2] = 32'd0;
    snap_exp[3] = 32'd3;

    // Reset state
    step(2);
    reset = 1'b0;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    bus_rd(0, 2, d); check("rst_period0", d, 32'd49999);
    bus_rd(3, 0, d); check("rst_status3", d, 32'd0);
    bus_rd(1, 1, d); check("rst_control1", d, 32'd0);

    // Ch0 periodic: PERIOD=4, PRESCALE=0, ITO|CONT|START -> TO five clocks after START
    bus_wr(0, 2, 32'd4);
    bus_wr(0, 4, 32'd0);
    bus_wr(0, 1, 32'h7);
    step(4);
    check("p0_irq_before", 32'(irq), 32'd0);
    step(1);
    check("p0_irq_at_to", 32'(irq), 32'd1);
    check("p0_irq_vec", 32'(irq_vec), 32'h1);
    for (int k = 0; k < 4; k++) begin
      bus_wr(0, 3, 32'd0);
      bus_rd(0, 3, d);
      check($sformatf("p0_snap%0d", k), d, snap_exp[k]);
    end
    bus_wr(0, 1, 32'h8);
    bus_wr(0, 0, 32'd0);
    check("p0_irq_cleared", 32'(irq), 32'd0);

    // Ch1 one-shot: PERIOD=2, PRESCALE=3 -> single timeout 12 clocks after START
    bus_wr(1, 2, 32'd2);
    bus_wr(1, 4, 32'd3);
    bus_wr(1, 1, 32'h5);
    step(11);
    check("os_vec_before", 32'(irq_vec), 32'h0);
    step(1);
    check("os_vec_at_to", 32'(irq_vec), 32'h2);
    check("os_irq", 32'(irq), 32'd1);
    bus_rd(3, 5, d); check("os_irqsum_ch3", d, 32'h2);
    bus_rd(1, 0, d); check("os_status", d, 32'h1);
    bus_wr(1, 0, 32'd0);
    check("os_vec_cleared", 32'(irq_vec), 32'h0);

    // Chain: ch0 PERIOD=1 CONT feeds ch1 PERIOD=2 -> ch1 TO every 6 clocks
    bus_wr(1, 2, 32'd2);
    bus_wr(0, 2, 32'd1);
    bus_wr(1, 1, 32'h17);
    bus_wr(0, 1, 32'h6);
    step(5);
    check("ch_vec_t5", 32'(irq_vec), 32'h0);
    step(1);
    check("ch_vec_t6", 32'(irq_vec), 32'h2);
    bus_wr(1, 0, 32'd0);
    check("ch_vec_t7", 32'(irq_vec), 32'h0);
    step(4);
    check("ch_vec_t11", 32'(irq_vec), 32'h0);
    step(1);
    check("ch_vec_t12", 32'(irq_vec), 32'h2);
    bus_wr(0, 1, 32'h8);
    bus_wr(1, 1, 32'h8);
    bus_wr(1, 0, 32'd0);
    check("ch_irq_stopped", 32'(irq), 32'd0);

    // PERIOD rewrite while running: RUN drops, counter becomes 10, START resumes from 10
    bus_wr(2, 2, 32'd20);
    bus_wr(2, 1, 32'h6);
    step(3);
    bus_wr(2, 2, 32'd10);
    step(1);
    bus_wr(2, 3, 32'd0);
    bus_rd(2, 3, d); check("pw_counter", d, 32'd10);
    bus_rd(2, 0, d); check("pw_status", d, 32'd0);
    bus_wr(2, 1, 32'h6);
    bus_wr(2, 3, 32'd0);
    bus_rd(2, 3, d); check("pw_resume", d, 32'd10);
    bus_wr(2, 3, 32'd0);
    bus_rd(2, 3, d); check("pw_count2", d, 32'd8);
    bus_wr(2, 1, 32'h8);

    // START on the force-reload cycle
    bus_wr(3, 2, 32'd5);
    bus_wr(3, 1, 32'h4);
    bus_wr(3, 3, 32'd0);
    bus_rd(3, 3, d); check("fr_counter", d, 32'd5);
    bus_rd(3, 0, d); check("fr_status", d, 32'h2);
    bus_wr(3, 1, 32'h8);

    // STATUS clear on the exact timeout cycle
    bus_wr(0, 2, 32'd4);
    bus_wr(0, 1, 32'h7);
    step(4);
    bus_wr(0, 0, 32'd0);
    check("clr_race_vec", 32'(irq_vec), 32'h0);
    bus_rd(0, 0, d); check("clr_race_status", d, 32'h2);
    bus_wr(0, 1, 32'h8);
    bus_rd(0, 0, d); check("stop_status", d, 32'h0);
    bus_wr(0, 1, 32'hC);
    bus_rd(0, 0, d); check("startstop_status", d, 32'h2);
    bus_rd(0, 1, d); check("startstop_control", d, 32'h0);
    bus_rd(0, 7, d); check("reserved7", d, 32'h0);

    // Reset mid-count
    bus_wr(1, 2, 32'd3);
    bus_wr(1, 1, 32'h7);
    step(6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mr_readdata", readdata, 32'd0);
    check("mr_irq", 32'(irq), 32'd0);
    check("mr_irq_vec", 32'(irq_vec), 32'd0);
    bus_rd(1, 2, d); check("mr_period", d, 32'd49999);
    bus_rd(1, 0, d); check("mr_status", d, 32'd0);
    bus_rd(1, 3, d); check("mr_snap", d, 32'd0);
    bus_rd(1, 4, d); check("mr_prescale", d, 32'd0);
    step(30);
    check("mr_irq_later", 32'(irq_vec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
